// File: rtl/dshot_frame_supervisor.sv
// -----------------------------------------------------------------------------
// dshot_frame_supervisor
// Checks the CRC of each decoded DShot frame. Runs the arm/failsafe state
// machine. Turns throttle frames into a gated throttle value. Qualifies
// special commands with a repeat count before issuing them downstream.
// All outputs are registered in the clk domain and react one cycle after
// frame_strobe.
//
// Ports:
//   clk            in   system clock
//   reset          in   synchronous, active-high reset
//   frame_strobe   in   one-cycle pulse, frame_data holds a complete frame
//   frame_data     in   [15:5] value, [4] telemetry request, [3:0] CRC
//   throttle       out  gated throttle, 0..1999
//   throttle_valid out  pulse when throttle is updated from a frame in ARMED
//   armed          out  high in ARMED
//   failsafe       out  high in FAILSAFE
//   cmd_out        out  last issued command, 1..47
//   cmd_strobe     out  pulse when a command is issued
//   spin_dir       out  0 = normal, 1 = reversed
//   telem_req      out  pulse for a good frame with the telemetry bit set
//   crc_err_count  out  saturating count of CRC-failed frames
//
// Build option:
//   DSHOT_INV_CRC_EN  when defined, the CRC nibble is expected inverted
//                     (bidirectional DShot)
// -----------------------------------------------------------------------------
module dshot_frame_supervisor #(
    parameter int unsigned ARM_FRAMES     = 50,
    parameter int unsigned TIMEOUT_CYCLES = 1600000,
    parameter int unsigned CMD_REPEAT     = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_strobe,
    input  logic [15:0] frame_data,
    output logic [10:0] throttle,
    output logic        throttle_valid,
    output logic        armed,
    output logic        failsafe,
    output logic [5:0]  cmd_out,
    output logic        cmd_strobe,
    output logic        spin_dir,
    output logic        telem_req,
    output logic [7:0]  crc_err_count
);

    localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned REP_W   = 4;
    localparam int unsigned ARM_W   = 8;
    localparam int unsigned CMD_MAX = 47;
    localparam int unsigned THR_MIN = 48;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_FAILSAFE = 2'd2
    } state_e;

    state_e             state_q;
    logic [ARM_W-1:0]   arm_cnt_q;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [5:0]         last_cmd_q, last_cmd_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;

    logic [10:0]        throttle_q;
    logic               throttle_valid_q;
    logic               armed_q;
    logic               failsafe_q;
    logic [5:0]         cmd_out_q;
    logic               cmd_strobe_q;
    logic               spin_dir_q;
    logic               telem_req_q;
    logic [7:0]         crc_err_q;

    logic [11:0]        body;
    logic [3:0]         crc_calc;
    logic               crc_ok;
    logic               good;
    logic               bad;
    logic [10:0]        value;
    logic               is_zero;
    logic               is_cmd;
    logic               is_thr;
    logic               cmd_eligible;
    logic               cmd_same;
    logic               cmd_take;
    logic               cmd_issue;
    logic               tmo_expire;

    // Frame decode and CRC check
    always_comb begin
        body     = frame_data[15:4];
        crc_calc = body[3:0] ^ body[7:4] ^ body[11:8];
`ifdef DSHOT_INV_CRC_EN
        crc_ok   = (~crc_calc) == frame_data[3:0];
`else
        crc_ok   = crc_calc == frame_data[3:0];
`endif
        good     = frame_strobe && crc_ok;
        bad      = frame_strobe && !crc_ok;
        value    = frame_data[15:5];
        is_zero  = value == 11'd0;
        is_cmd   = !is_zero && (value <= 11'(CMD_MAX));
        is_thr   = value >= 11'(THR_MIN);
    end

    // Silence counter; expiry fires only on the step that reaches the limit,
    // and a good frame in the same cycle suppresses it
    always_comb begin
        tmo_expire = !good && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
        if (good) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES)) begin
            tmo_d = tmo_q;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    // Command repeat qualification
    always_comb begin
        cmd_eligible = (state_q == ST_DISARMED) ||
                       ((state_q == ST_ARMED) && (throttle_q == 11'd0));
        cmd_same     = value[5:0] == last_cmd_q;
        cmd_take     = good && is_cmd && cmd_eligible;
        rep_d        = rep_q;
        last_cmd_d   = last_cmd_q;
        if (cmd_take) begin
            last_cmd_d = value[5:0];
            if (!cmd_same) begin
                rep_d = REP_W'(1);
            end else if (rep_q != REP_W'(CMD_REPEAT)) begin
                rep_d = rep_q + REP_W'(1);
            end
        end else if (good) begin
            rep_d = '0;
        end
        // A saturated run of the same command must not re-issue
        cmd_issue = cmd_take && (rep_d == REP_W'(CMD_REPEAT)) &&
                    !(cmd_same && (rep_q == REP_W'(CMD_REPEAT)));
    end

    // State machine and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_DISARMED;
            arm_cnt_q        <= '0;
            rep_q            <= '0;
            last_cmd_q       <= '0;
            tmo_q            <= '0;
            throttle_q       <= '0;
            throttle_valid_q <= 1'b0;
            armed_q          <= 1'b0;
            failsafe_q       <= 1'b0;
            cmd_out_q        <= '0;
            cmd_strobe_q     <= 1'b0;
            spin_dir_q       <= 1'b0;
            telem_req_q      <= 1'b0;
            crc_err_q        <= '0;
        end else begin
            throttle_valid_q <= 1'b0;
            cmd_strobe_q     <= 1'b0;
            telem_req_q      <= good && frame_data[4];
            tmo_q            <= tmo_d;
            rep_q            <= rep_d;
            last_cmd_q       <= last_cmd_d;

            if (bad && (crc_err_q != 8'hFF)) begin
                crc_err_q <= crc_err_q + 8'd1;
            end

            if (cmd_issue) begin
                cmd_out_q    <= value[5:0];
                cmd_strobe_q <= 1'b1;
                if (value == 11'd7) begin
                    spin_dir_q <= 1'b0;
                end else if (value == 11'd8) begin
                    spin_dir_q <= 1'b1;
                end
            end

            case (state_q)
                ST_ARMED: begin
                    if (good) begin
                        if (is_thr) begin
                            throttle_q       <= value - 11'(THR_MIN);
                            throttle_valid_q <= 1'b1;
                        end else if (is_zero) begin
                            throttle_q       <= '0;
                            throttle_valid_q <= 1'b1;
                        end
                    end else if (tmo_expire) begin
                        state_q    <= ST_FAILSAFE;
                        armed_q    <= 1'b0;
                        failsafe_q <= 1'b1;
                        throttle_q <= '0;
                    end
                end
                ST_DISARMED, ST_FAILSAFE: begin
                    if (good) begin
                        if (is_zero) begin
                            if (arm_cnt_q == ARM_W'(ARM_FRAMES - 1)) begin
                                state_q    <= ST_ARMED;
                                armed_q    <= 1'b1;
                                failsafe_q <= 1'b0;
                                arm_cnt_q  <= '0;
                            end else begin
                                arm_cnt_q <= arm_cnt_q + ARM_W'(1);
                            end
                        end else begin
                            arm_cnt_q <= '0;
                        end
                    end else if (tmo_expire) begin
                        arm_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_DISARMED;
                end
            endcase
        end
    end

    assign throttle       = throttle_q;
    assign throttle_valid = throttle_valid_q;
    assign armed          = armed_q;
    assign failsafe       = failsafe_q;
    assign cmd_out        = cmd_out_q;
    assign cmd_strobe     = cmd_strobe_q;
    assign spin_dir       = spin_dir_q;
    assign telem_req      = telem_req_q;
    assign crc_err_count  = crc_err_q;

endmodule

// File: tb/tb_dshot_frame_supervisor.sv
// -----------------------------------------------------------------------------
// Bench for dshot_frame_supervisor with ARM_FRAMES=3, TIMEOUT_CYCLES=100,
// CMD_REPEAT=6. A behavioural model tracks the expected outputs every cycle.
// Directed literal checks pin the key points of each scenario.
// -----------------------------------------------------------------------------
module tb_dshot_frame_supervisor;

    localparam int ARM = 3;
    localparam int TMO = 100;
    localparam int REP = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_strobe;
    logic [15:0] frame_data;
    logic [10:0] throttle;
    logic        throttle_valid;
    logic        armed;
    logic        failsafe;
    logic [5:0]  cmd_out;
    logic        cmd_strobe;
    logic        spin_dir;
    logic        telem_req;
    logic [7:0]  crc_err_count;

    int n_cmp = 0;
    int n_bad = 0;

    dshot_frame_supervisor #(
        .ARM_FRAMES     (ARM),
        .TIMEOUT_CYCLES (TMO),
        .CMD_REPEAT     (REP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .frame_strobe   (frame_strobe),
        .frame_data     (frame_data),
        .throttle       (throttle),
        .throttle_valid (throttle_valid),
        .armed          (armed),
        .failsafe       (failsafe),
        .cmd_out        (cmd_out),
        .cmd_strobe     (cmd_strobe),
        .spin_dir       (spin_dir),
        .telem_req      (telem_req),
        .crc_err_count  (crc_err_count)
    );

    always #5 clk = ~clk;

    // CRC straight from the shift/xor definition
    function automatic logic [3:0] crc4(input logic [11:0] d);
        logic [11:0] c;
        c = d ^ (d >> 4) ^ (d >> 8);
`ifdef DSHOT_INV_CRC_EN
        return ~c[3:0];
`else
        return c[3:0];
`endif
    endfunction

    function automatic logic [15:0] mk(input int v, input logic t);
        logic [11:0] d;
        d = {11'(v), t};
        return {d, crc4(d)};
    endfunction

    // ---------------- behavioural model ----------------
    localparam int M_DIS = 0;
    localparam int M_ARM = 1;
    localparam int M_FS  = 2;

    int mode, arm_run, cmd_run, last_cmd, silent;
    bit m_valid = 1'b0;
    int e_thr, e_tv, e_cmd, e_cs, e_spin, e_tr, e_err;

    task automatic model_step();
        bit good, expire, elig;
        int v;
        e_tv = 0; e_cs = 0; e_tr = 0;
        if (reset) begin
            mode = M_DIS; arm_run = 0; cmd_run = 0; last_cmd = 0; silent = 0;
            e_thr = 0; e_cmd = 0; e_spin = 0; e_err = 0;
            m_valid = 1'b1;
            return;
        end
        good = frame_strobe && (frame_data[3:0] == crc4(frame_data[15:4]));
        v = int'(frame_data[15:5]);
        if (frame_strobe && !good && e_err < 255) e_err++;
        expire = 1'b0;
        if (good) silent = 0;
        else if (silent < TMO) begin
            silent++;
            expire = (silent == TMO);
        end
        if (good) begin
            e_tr = int'(frame_data[4]);
            elig = (mode == M_DIS) || (mode == M_ARM && e_thr == 0);
            if (v >= 1 && v <= 47 && elig) begin
                if (v == last_cmd) cmd_run++;
                else begin last_cmd = v; cmd_run = 1; end
                if (cmd_run == REP) begin
                    e_cs = 1; e_cmd = v;
                    if (v == 7) e_spin = 0;
                    if (v == 8) e_spin = 1;
                end
            end else cmd_run = 0;
            if (mode == M_ARM) begin
                if (v >= 48) begin e_thr = v - 48; e_tv = 1; end
                else if (v == 0) begin e_thr = 0; e_tv = 1; end
            end else begin
                if (v == 0) begin
                    arm_run++;
                    if (arm_run == ARM) begin mode = M_ARM; arm_run = 0; end
                end else arm_run = 0;
            end
        end else if (expire) begin
            if (mode == M_ARM) begin mode = M_FS; e_thr = 0; end
            else arm_run = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("m_throttle",  32'(throttle),       32'(e_thr));
            chk("m_thr_valid", 32'(throttle_valid), 32'(e_tv));
            chk("m_armed",     32'(armed),          32'(mode == M_ARM));
            chk("m_failsafe",  32'(failsafe),       32'(mode == M_FS));
            chk("m_cmd_out",   32'(cmd_out),        32'(e_cmd));
            chk("m_cmd_strb",  32'(cmd_strobe),     32'(e_cs));
            chk("m_spin_dir",  32'(spin_dir),       32'(e_spin));
            chk("m_telem",     32'(telem_req),      32'(e_tr));
            chk("m_crc_err",   32'(crc_err_count),  32'(e_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic s, input logic [15:0] d);
        @(negedge clk);
        frame_strobe = s;
        frame_data   = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 16'h0000);
    endtask

    task automatic send(input logic [15:0] d, input int n);
        repeat (n) drive(1'b1, d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; frame_strobe = 1'b0; frame_data = 16'h0000;
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [15:0] zf, t999, t0, c7, c8, badf, telf;

    initial begin
        reset = 1'b1; frame_strobe = 1'b0; frame_data = 16'h0000;
        zf   = mk(0, 1'b0);
        t999 = mk(1047, 1'b0);
        t0   = mk(48, 1'b0);
        c7   = mk(7, 1'b0);
        c8   = mk(8, 1'b0);
        telf = mk(0, 1'b1);
        badf = t999 ^ 16'h0001;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // reset state
        chk("rst_throttle", 32'(throttle), 32'd0);
        chk("rst_armed",    32'(armed),    32'd0);
        chk("rst_failsafe", 32'(failsafe), 32'd0);
        chk("rst_crc_err",  32'(crc_err_count), 32'd0);
        chk("rst_spin",     32'(spin_dir), 32'd0);

        // arming
        send(zf, 2); idle(1);
        chk("arm_after2", 32'(armed), 32'd0);
        send(zf, 1); idle(1);
        chk("arm_after3", 32'(armed), 32'd1);

        // interrupted arming run
        do_reset();
        send(zf, 2); send(t999, 1); send(zf, 2); idle(1);
        chk("arm_broken", 32'(armed), 32'd0);
        send(zf, 1); idle(1);
        chk("arm_rerun", 32'(armed), 32'd1);
        chk("arm_thr0",  32'(throttle), 32'd0);

        // throttle
        send(t999, 1); idle(1);
        chk("thr_999",   32'(throttle), 32'd999);
        chk("thr_valid", 32'(throttle_valid), 32'd1);
        idle(1);
        chk("thr_vpulse", 32'(throttle_valid), 32'd0);
        send(t0, 1); idle(1);
        chk("thr_48", 32'(throttle), 32'd0);
        send(t999, 1); idle(1);

        // CRC errors
        send(badf, 1); idle(1);
        chk("crc_one",   32'(crc_err_count), 32'd1);
        chk("crc_thr",   32'(throttle), 32'd999);
        chk("crc_telem", 32'(telem_req), 32'd0);
        send(badf, 300); idle(1);
        chk("crc_sat",   32'(crc_err_count), 32'd255);
        chk("crc_tmo_fs", 32'(failsafe), 32'd1);

        // timeout
        send(zf, 3); idle(1);
        chk("rearm_armed", 32'(armed), 32'd1);
        chk("rearm_fs",    32'(failsafe), 32'd0);
        send(t999, 1); idle(100);
        chk("tmo_99_fs", 32'(failsafe), 32'd0);
        idle(1);
        chk("tmo_fs",    32'(failsafe), 32'd1);
        chk("tmo_armed", 32'(armed), 32'd0);
        chk("tmo_thr",   32'(throttle), 32'd0);
        send(c8, 6); idle(1);
        chk("fs_no_cmd", 32'(cmd_strobe), 32'd0);
        chk("fs_spin",   32'(spin_dir), 32'd0);
        send(zf, 3); send(t999, 1); idle(99); send(t999, 1); idle(1);
        chk("tmo_edge_fs",  32'(failsafe), 32'd0);
        chk("tmo_edge_arm", 32'(armed), 32'd1);
        chk("tmo_edge_thr", 32'(throttle), 32'd999);

        // commands while disarmed
        do_reset();
        send(c8, 6); idle(1);
        chk("cmd8_strobe", 32'(cmd_strobe), 32'd1);
        chk("cmd8_out",    32'(cmd_out), 32'd8);
        chk("cmd8_spin",   32'(spin_dir), 32'd1);
        send(c8, 1); idle(1);
        chk("cmd8_7th", 32'(cmd_strobe), 32'd0);
        send(c7, 5); send(zf, 1); send(c7, 6); idle(1);
        chk("cmd7_strobe", 32'(cmd_strobe), 32'd1);
        chk("cmd7_out",    32'(cmd_out), 32'd7);
        chk("cmd7_spin",   32'(spin_dir), 32'd0);
        send(telf, 1); idle(1);
        chk("telem_pulse", 32'(telem_req), 32'd1);

        // eligibility while armed
        send(zf, 3); idle(1);
        chk("elig_armed", 32'(armed), 32'd1);
        send(c7, 6); idle(1);
        chk("elig_t0_cmd7", 32'(cmd_strobe), 32'd1);
        send(c8, 6); idle(1);
        chk("elig_t0_spin", 32'(spin_dir), 32'd1);
        send(t999, 1); send(c8, 6); idle(1);
        chk("inelig_strobe", 32'(cmd_strobe), 32'd0);
        chk("inelig_thr",    32'(throttle), 32'd999);
        chk("inelig_spin",   32'(spin_dir), 32'd1);

        // reset in the middle of a command run
        send(c8, 3);
        @(negedge clk);
        reset = 1'b1; frame_strobe = 1'b1; frame_data = c8;
        @(negedge clk);
        reset = 1'b0; frame_strobe = 1'b0;
        chk("midrst_armed", 32'(armed), 32'd0);
        chk("midrst_thr",   32'(throttle), 32'd0);
        chk("midrst_spin",  32'(spin_dir), 32'd0);
        chk("midrst_cmd",   32'(cmd_out), 32'd0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
